delay_req_issuer: RTL and testbench
===================================

# delay_req_issuer

Initiator for the ready/valid delay counter. Accepts tagged delay requests from upstream, buffers them in a small FIFO, and presents each to the counter's `counter_vld` / `counter_until_this` inputs. It tracks the single outstanding delay and emits a one-cycle tagged completion when the counter reports `counter_reached`. It sits between a command producer (scheduler or sequencer) and one delay counter instance that shares its `clk` and `rst`.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `TAG_W`, 4: request tag width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_vld` in 1: upstream request valid.
- `req_rdy` out 1: upstream ready; equals `!full`.
- `req_delay` in 8: requested delay in cycles, 0 to 255.
- `req_tag` in TAG_W: opaque tag returned on completion.
- `counter_vld` out 1: a delay is presented to the counter.
- `counter_until_this` out 8: delay presented to the counter.
- `counter_reached` in 1: counter's reached flag; counter is idle or its target has been hit.
- `done_vld` out 1: one-cycle completion pulse.
- `done_tag` out TAG_W: tag of the completed request; valid only while `done_vld` is high.
- `inflight` out 1: a delay is outstanding in the counter.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO:** circular buffer of {delay, tag} with read/write pointers one bit wider than the index.
  - `full` when the index bits match and the MSBs differ. `empty` when the pointers are equal.
  - push = `req_vld && req_rdy`. pop = issue.
- **Counter drive:** `counter_vld = !empty`, `counter_until_this` = head delay, 0 when empty.
  - issue = `counter_vld && counter_reached`, sampled at the rising edge.
- **FSM:**
  - IDLE → BUSY on issue. `inflight_tag` ← head tag.
  - BUSY with `counter_reached` high and no issue → IDLE, and completes the request.
  - BUSY with `counter_reached` and issue on the same edge → stays BUSY. It completes the old tag and latches the new tag (back-to-back).
  - BUSY with `counter_reached` low → hold.
- **Completion:** `done_vld` and `done_tag` are registered. They are set for one cycle after the completing edge (state BUSY and `counter_reached` sampled high). Otherwise `done_vld` = 0.
- `inflight` = (state == BUSY).
- **No bypass:** a request pushed into an empty FIFO issues at the earliest on the following edge.
- **Full:** `req_rdy` is low when full, even if a pop happens on the same edge. There is no combinational path from `counter_reached` to `req_rdy`.
- Simultaneous push and pop with the FIFO neither full nor empty: occupancy is unchanged and both pointers advance.
- Pointer wrap-around is natural modulo 2·DEPTH.

## Timing
- **Reset (async assert, deasserted synchronously to `clk` by the system):**
  - state IDLE, pointers 0, `fifo_count` 0.
  - `req_rdy` = 1, `counter_vld` = 0, `counter_until_this` = 0.
  - `done_vld` = 0, `done_tag` = 0, `inflight` = 0.
- **Reset mid-operation:** queued and outstanding requests are discarded with no completion pulse. The counter is reset by the same `rst`, so `counter_reached` is high afterwards.
- **Latency:** the request is accepted at edge P. The issue edge is at the earliest P+1, while the counter is idle. For delay N issued at edge E:
  - The completion edge is E+N+1.
  - `done_vld` is high in the cycle after E+N+1.
  - N = 0 completes at E+1.
- **Back-to-back:** the next request issues on the completion edge. Consecutive delays N1, N2 complete N2+1 edges apart.
- **Throughput:** one request per N+1 cycles at the counter. Upstream is throttled only by FIFO full.

## Test plan
- Reset with FIFO half full and BUSY → all outputs at reset values; no `done_vld` afterwards; `counter_reached` high.
- Single request {delay 3, tag 5} pushed at edge 1 → issue at edge 2; `done_vld` = 1, `done_tag` = 5 in the cycle after edge 6; `inflight` high between.
- Requests {0, tag 1}, {1, tag 2}, {3, tag 3} pushed on consecutive edges 1–3:
  - issues at edges 2, 3, 5;
  - `done_vld` in the cycles after edges 3, 5, 9, with tags 1, 2, 3 in order;
  - no idle gap at the counter.
- Push DEPTH+2 requests of delay 5 with `req_vld` held:
  - `req_rdy` drops when `fifo_count` = DEPTH;
  - `req_rdy` is still low on the pop edge and returns the cycle after;
  - no request is lost or duplicated; tags are returned in order across pointer wrap.
- Random delays 0–255, random `req_vld`, 1000 requests → completions match a reference queue. Each request satisfies completion edge − issue edge = delay + 1, and `fifo_count` never exceeds DEPTH.

Source files
------------

// File: rtl/delay_req_issuer.sv
// delay_req_issuer: queues tagged delay requests and issues them one at a time
// to a ready/valid delay counter, reporting a tagged completion pulse when the
// counter signals that the outstanding delay has elapsed.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_vld/req_rdy           upstream handshake; req_rdy = !full
//   req_delay, req_tag        request payload (delay 0..255, opaque tag)
//   counter_vld               head of queue presented to the counter
//   counter_until_this        head delay, 0 when the queue is empty
//   counter_reached           counter idle / target hit
//   done_vld, done_tag        registered one-cycle completion pulse and tag
//   inflight                  a delay is outstanding in the counter
//   fifo_count                current queue occupancy
module delay_req_issuer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_vld,
   output logic                     req_rdy,
   input  logic [7:0]               req_delay,
   input  logic [TAG_W-1:0]         req_tag,
   output logic                     counter_vld,
   output logic [7:0]               counter_until_this,
   input  logic                     counter_reached,
   output logic                     done_vld,
   output logic [TAG_W-1:0]         done_tag,
   output logic                     inflight,
   output logic [$clog2(DEPTH):0]   fifo_count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   typedef struct packed {
      logic [7:0]       delay;
      logic [TAG_W-1:0] tag;
   } entry_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   entry_t              mem [DEPTH];
   logic [PTR_W-1:0]    wptr;
   logic [PTR_W-1:0]    rptr;
   entry_t              head;
   logic                full;
   logic                empty;
   logic                push;
   logic                issue;
   state_t              state;
   logic [TAG_W-1:0]    inflight_tag;

   // Queue status from the extra pointer MSB.
   assign empty = (wptr == rptr);
   assign full  = (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]) && (wptr[IDX_W] != rptr[IDX_W]);
   assign head  = mem[rptr[IDX_W-1:0]];

   // req_rdy depends only on registered pointers, never on counter_reached.
   assign req_rdy    = !full;
   assign push       = req_vld && !full;
   assign issue      = !empty && counter_reached;
   assign fifo_count = wptr - rptr;

   assign counter_vld        = !empty;
   assign counter_until_this = empty ? 8'd0 : head.delay;
   assign inflight           = (state == BUSY);

   // Payload storage; contents need no reset since empty masks the head.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wptr[IDX_W-1:0]] <= '{delay: req_delay, tag: req_tag};
      end
   end

   // Pointers wrap naturally modulo 2*DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + PTR_W'(1);
         if (issue) rptr <= rptr + PTR_W'(1);
      end
   end

   // Outstanding-delay tracker with registered completion pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         inflight_tag <= '0;
         done_vld     <= 1'b0;
         done_tag     <= '0;
      end else begin
         done_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (issue) begin
                  state        <= BUSY;
                  inflight_tag <= head.tag;
               end
            end
            BUSY: begin
               if (counter_reached) begin
                  done_vld <= 1'b1;
                  done_tag <= inflight_tag;
                  // Back-to-back: the next request issues on the completion edge.
                  if (issue) begin
                     inflight_tag <= head.tag;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_delay_req_issuer.sv
// Testbench for delay_req_issuer: directed scenarios plus a randomized run
// checked against a reference queue, with a behavioural delay counter model.
module tb_delay_req_issuer;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 4;

   logic             clk;
   logic             rst;
   logic             req_vld;
   logic             req_rdy;
   logic [7:0]       req_delay;
   logic [TAG_W-1:0] req_tag;
   logic             counter_vld;
   logic [7:0]       counter_until_this;
   logic             counter_reached;
   logic             done_vld;
   logic [TAG_W-1:0] done_tag;
   logic             inflight;
   logic [2:0]       fifo_count;

   int checks = 0;
   int errors = 0;

   delay_req_issuer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk                (clk),
      .rst                (rst),
      .req_vld            (req_vld),
      .req_rdy            (req_rdy),
      .req_delay          (req_delay),
      .req_tag            (req_tag),
      .counter_vld        (counter_vld),
      .counter_until_this (counter_until_this),
      .counter_reached    (counter_reached),
      .done_vld           (done_vld),
      .done_tag           (done_tag),
      .inflight           (inflight),
      .fifo_count         (fifo_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Delay counter model: a target N accepted at edge E reports reached at E+N+1.
   logic [7:0] cnt_q;
   always @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= 8'd0;
      else if (counter_vld && counter_reached) cnt_q <= counter_until_this;
      else if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
   end
   assign counter_reached = (cnt_q == 8'd0);

   // Reference scoreboard used during the randomized run.
   typedef struct {
      int d;
      int t;
      int e;
   } rec_t;

   rec_t pq[$];
   rec_t oq[$];
   bit   mon_en   = 1'b0;
   int   mon_edge = 0;
   int   done_cnt = 0;

   always @(posedge clk) begin
      if (mon_en) begin
         rec_t r;
         mon_edge = mon_edge + 1;
         if (done_vld) begin
            checks++;
            if (oq.size() == 0) begin
               errors++;
               $display("FAIL rand_done_spurious got tag %0d, expected no completion", done_tag);
            end else begin
               if (done_tag !== TAG_W'(oq[0].t)) begin
                  errors++;
                  $display("FAIL rand_done_tag got %0d expected %0d", done_tag, oq[0].t);
               end
               checks++;
               if ((mon_edge - 1) - oq[0].e != oq[0].d + 1) begin
                  errors++;
                  $display("FAIL rand_latency got %0d expected %0d", (mon_edge - 1) - oq[0].e, oq[0].d + 1);
               end
               void'(oq.pop_front());
               done_cnt++;
            end
         end
         if (counter_vld && counter_reached) begin
            checks++;
            if (pq.size() == 0) begin
               errors++;
               $display("FAIL rand_issue_empty got issue with delay %0d, expected none", counter_until_this);
            end else begin
               if (counter_until_this !== 8'(pq[0].d)) begin
                  errors++;
                  $display("FAIL rand_issue_delay got %0d expected %0d", counter_until_this, pq[0].d);
               end
               r   = pq.pop_front();
               r.e = mon_edge;
               oq.push_back(r);
            end
         end
         if (req_vld && req_rdy) begin
            r.d = int'(req_delay);
            r.t = int'(req_tag);
            r.e = 0;
            pq.push_back(r);
         end
         checks++;
         if (fifo_count > 3'(DEPTH)) begin
            errors++;
            $display("FAIL rand_fifo_count got %0d expected <= %0d", fifo_count, DEPTH);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while ((inflight || fifo_count != 3'd0 || done_vld) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 1000) begin
         errors++;
         $display("FAIL idle_timeout got inflight %0d count %0d, expected idle", inflight, fifo_count);
      end
   endtask

   task automatic check_reset_outputs(input string name);
      checks++;
      if (req_rdy !== 1'b1 || counter_vld !== 1'b0 || counter_until_this !== 8'd0 ||
          done_vld !== 1'b0 || done_tag !== '0 || inflight !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL %s got rdy %b cvld %b until %0d done %b tag %0d infl %b cnt %0d expected 1 0 0 0 0 0 0",
                  name, req_rdy, counter_vld, counter_until_this, done_vld, done_tag, inflight, fifo_count);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req_vld = 1'b0; req_delay = 8'd0; req_tag = '0;
      #1;
      check_reset_outputs("reset_during");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset_after");
      checks++;
      if (counter_reached !== 1'b1) begin
         errors++;
         $display("FAIL reset_reached got %b expected 1", counter_reached);
      end
   endtask

   task automatic test_single();
      req_vld = 1'b1; req_delay = 8'd3; req_tag = 4'd5;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         req_vld = 1'b0;
         if (k == 1) begin
            checks++;
            if (counter_vld !== 1'b1 || counter_until_this !== 8'd3 || fifo_count !== 3'd1 || inflight !== 1'b0) begin
               errors++;
               $display("FAIL single_queued got cvld %b until %0d cnt %0d infl %b expected 1 3 1 0",
                        counter_vld, counter_until_this, fifo_count, inflight);
            end
         end
         checks++;
         if (done_vld !== (k == 6) || inflight !== (k >= 2 && k <= 5)) begin
            errors++;
            $display("FAIL single_edge%0d got done %b infl %b expected %b %b",
                     k, done_vld, inflight, k == 6, k >= 2 && k <= 5);
         end
         if (k == 6) begin
            checks++;
            if (done_tag !== 4'd5) begin
               errors++;
               $display("FAIL single_tag got %0d expected 5", done_tag);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] dly [3];
      logic [7:0] exp_until [4];
      dly = '{8'd0, 8'd1, 8'd3};
      exp_until = '{8'd0, 8'd1, 8'd3, 8'd3};
      req_vld = 1'b1; req_delay = dly[0]; req_tag = 4'd1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k < 3) begin
            req_delay = dly[k];
            req_tag   = TAG_W'(k + 1);
         end else begin
            req_vld = 1'b0;
         end
         checks++;
         if (done_vld !== (k == 3 || k == 5 || k == 9) || inflight !== (k >= 2 && k <= 8) ||
             counter_vld !== (k <= 4)) begin
            errors++;
            $display("FAIL b2b_edge%0d got done %b infl %b cvld %b expected %b %b %b", k, done_vld, inflight,
                     counter_vld, k == 3 || k == 5 || k == 9, k >= 2 && k <= 8, k <= 4);
         end
         if (k <= 4) begin
            checks++;
            if (counter_until_this !== exp_until[k-1]) begin
               errors++;
               $display("FAIL b2b_until%0d got %0d expected %0d", k, counter_until_this, exp_until[k-1]);
            end
         end
         if (done_vld) begin
            checks++;
            if (done_tag !== ((k == 3) ? 4'd1 : (k == 5) ? 4'd2 : 4'd3)) begin
               errors++;
               $display("FAIL b2b_tag_edge%0d got %0d expected %0d", k, done_tag,
                        (k == 3) ? 1 : (k == 5) ? 2 : 3);
            end
         end
      end
   endtask

   task automatic test_full();
      int  tag_next = 0;
      int  got      = 0;
      bit  acc;
      int  exp_cnt [9];
      bit  exp_rdy [9];
      exp_cnt = '{1, 1, 2, 3, 4, 4, 4, 3, 4};
      exp_rdy = '{1, 1, 1, 1, 0, 0, 0, 1, 0};
      req_vld = 1'b1; req_delay = 8'd5; req_tag = 4'd0;
      acc = req_rdy;
      for (int k = 1; k <= 200; k++) begin
         @(negedge clk);
         if (acc) tag_next++;
         if (k <= 9) begin
            checks++;
            if (fifo_count !== 3'(exp_cnt[k-1]) || req_rdy !== exp_rdy[k-1]) begin
               errors++;
               $display("FAIL full_edge%0d got cnt %0d rdy %b expected %0d %b",
                        k, fifo_count, req_rdy, exp_cnt[k-1], exp_rdy[k-1]);
            end
         end
         if (done_vld) begin
            checks++;
            if (done_tag !== TAG_W'(got)) begin
               errors++;
               $display("FAIL full_order got %0d expected %0d", done_tag, got);
            end
            got++;
         end
         if (tag_next < DEPTH + 2) begin
            req_vld = 1'b1;
            req_tag = TAG_W'(tag_next);
         end else begin
            req_vld = 1'b0;
         end
         acc = req_vld && req_rdy;
         if (got == DEPTH + 2 && k > 9) break;
      end
      checks++;
      if (got != DEPTH + 2) begin
         errors++;
         $display("FAIL full_count got %0d completions expected %0d", got, DEPTH + 2);
      end
   endtask

   task automatic test_random();
      int sent = 0;
      int n    = 0;
      bit acc  = 1'b0;
      int r;
      pq.delete();
      oq.delete();
      done_cnt = 0;
      req_vld  = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;
      forever begin
         @(negedge clk);
         if (acc) sent++;
         if (sent == 1000) break;
         if (!req_vld || acc) begin
            req_vld = ($urandom_range(0, 1) == 1);
            if (sent == 0) req_delay = 8'd255;
            else if (sent == 1) req_delay = 8'd0;
            else begin
               r = int'($urandom_range(0, 7));
               req_delay = (r == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            end
            req_tag = TAG_W'(sent);
         end
         acc = req_vld && req_rdy;
      end
      req_vld = 1'b0;
      while (done_cnt < 1000 && n < 60000) begin
         @(negedge clk);
         n++;
      end
      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      checks++;
      if (done_cnt != 1000 || pq.size() != 0 || oq.size() != 0) begin
         errors++;
         $display("FAIL rand_drain got %0d completions, %0d queued, %0d outstanding expected 1000 0 0",
                  done_cnt, pq.size(), oq.size());
      end
   endtask

   task automatic test_reset_mid();
      req_vld = 1'b1; req_delay = 8'd20;
      for (int k = 0; k < 3; k++) begin
         req_tag = TAG_W'(7 + k);
         @(negedge clk);
      end
      req_vld = 1'b0;
      checks++;
      if (inflight !== 1'b1 || fifo_count !== 3'd2) begin
         errors++;
         $display("FAIL rstmid_pre got infl %b cnt %0d expected 1 2", inflight, fifo_count);
      end
      rst = 1'b1;
      #1;
      check_reset_outputs("rstmid_during");
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         checks++;
         if (done_vld !== 1'b0 || counter_reached !== 1'b1 || inflight !== 1'b0 || counter_vld !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after%0d got done %b reached %b infl %b cvld %b expected 0 1 0 0",
                     k, done_vld, counter_reached, inflight, counter_vld);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      wait_idle();
      test_back_to_back();
      wait_idle();
      test_full();
      wait_idle();
      test_random();
      wait_idle();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got no finish expected completion before timeout");
      $fatal(1, "watchdog");
   end

endmodule
